// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : mem_ctrl_pkg                                         |
// | Description : Shared types and helpers for the RAM sequencer:      |
// |               access-size codes, FSM states, beat-count function.  |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
package mem_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Number of byte beats for an access size; 11 is treated as a word.
    function automatic logic [2:0] beats_for(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl_rr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : mem_ctrl_rr_arb                                      |
// | Description : Two-requester round-robin arbiter. req[0] = fetch,   |
// |               req[1] = load/store. Grants only while en is high;   |
// |               on a tie the port not granted last wins.             |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
module mem_ctrl_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    // 1 when the load/store port received the most recent grant.
    // Resets to "fetch", so load/store wins the first tie.
    logic last_d;

    // Grant decode: single requester wins outright, a tie goes to the other port.
    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                grant = last_d ? 2'b01 : 2'b10;
            end else begin
                grant = req;
            end
        end
    end

    // Remember which port was granted whenever a grant is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d <= 1'b0;
        end else if (en && (|req)) begin
            last_d <= grant[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : mem_ctrl                                             |
// | Description : Arbitrates fetch and load/store ports onto an 8-bit  |
// |               single-port synchronous RAM, splitting accesses into |
// |               little-endian byte beats and assembling read data.   |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  if_req_in,
    input  logic [31:0]           if_addr_in,
    output logic                  if_done_out,
    output logic [31:0]           if_data_out,
    input  logic                  d_req_in,
    input  logic                  d_we_in,
    input  logic [1:0]            d_size_in,
    input  logic [31:0]           d_addr_in,
    input  logic [31:0]           d_wdata_in,
    output logic                  d_done_out,
    output logic [31:0]           d_rdata_out,
    output logic                  ram_en_out,
    output logic                  ram_r_nw_out,
    output logic [ADDR_WIDTH-1:0] ram_a_out,
    output logic [7:0]            ram_d_out,
    input  logic [7:0]            ram_d_in
);

    state_t                  state;
    state_t                  state_nxt;
    logic [1:0]              req_vec;
    logic [1:0]              grant;
    logic                    arb_en;
    logic                    owner_d;   // 1 = current transaction belongs to load/store
    logic [ADDR_WIDTH-1:0]   addr;
    logic [2:0]              n_beats;
    logic [2:0]              beat;      // RD counts 0..n (extra capture cycle), WR 0..n-1
    logic [31:0]             wdata;
    logic [31:0]             acc;
    logic [31:0]             acc_nxt;
    logic [1:0]              cap_idx;
    logic [31:0]             if_data;
    logic [31:0]             d_rdata;

    // Requester address bits above the RAM width carry no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, if_addr_in[31:ADDR_WIDTH], d_addr_in[31:ADDR_WIDTH]};

    assign req_vec = {d_req_in, if_req_in};
    assign arb_en  = (state == S_IDLE);

    mem_ctrl_rr_arb u_arb (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .en    (arb_en),
        .req   (req_vec),
        .grant (grant)
    );

    // State register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: reads take n beats plus one capture cycle, writes n beats.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (grant[1] && d_we_in) begin
                    state_nxt = S_WR;
                end else if (|grant) begin
                    state_nxt = S_RD;
                end
            end
            S_RD: begin
                if (beat == n_beats) begin
                    state_nxt = S_DONE;
                end
            end
            S_WR: begin
                if (beat == (n_beats - 3'd1)) begin
                    state_nxt = S_DONE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // The byte returned this cycle belongs to the beat issued one cycle earlier.
    always_comb begin
        acc_nxt = acc;
        cap_idx = 2'(beat - 3'd1);
        acc_nxt[{cap_idx, 3'b000} +: 8] = ram_d_in;
    end

    // Datapath: latch the granted request, step beats, assemble and publish read data.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            owner_d <= 1'b0;
            addr    <= '0;
            n_beats <= 3'd0;
            beat    <= 3'd0;
            wdata   <= 32'd0;
            acc     <= 32'd0;
            if_data <= 32'd0;
            d_rdata <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|grant) begin
                        owner_d <= grant[1];
                        addr    <= grant[1] ? d_addr_in[ADDR_WIDTH-1:0]
                                            : if_addr_in[ADDR_WIDTH-1:0];
                        n_beats <= grant[1] ? beats_for(d_size_in) : beats_for(SZ_WORD);
                        wdata   <= d_wdata_in;
                        beat    <= 3'd0;
                        acc     <= 32'd0;
                    end
                end
                S_RD: begin
                    beat <= beat + 3'd1;
                    if (beat != 3'd0) begin
                        acc <= acc_nxt;
                    end
                    if (beat == n_beats) begin
                        if (owner_d) begin
                            d_rdata <= acc_nxt;
                        end else begin
                            if_data <= acc_nxt;
                        end
                    end
                end
                S_WR: begin
                    beat <= beat + 3'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs: RAM pins are active only during beats, done pulses in DONE.
    always_comb begin
        ram_en_out   = 1'b0;
        ram_r_nw_out = 1'b0;
        ram_a_out    = '0;
        ram_d_out    = 8'd0;
        if_done_out  = 1'b0;
        d_done_out   = 1'b0;
        case (state)
            S_RD: begin
                if (beat < n_beats) begin
                    ram_en_out = 1'b1;
                    ram_a_out  = addr + ADDR_WIDTH'(beat);
                end
            end
            S_WR: begin
                ram_en_out   = 1'b1;
                ram_r_nw_out = 1'b1;
                ram_a_out    = addr + ADDR_WIDTH'(beat);
                ram_d_out    = wdata[{beat[1:0], 3'b000} +: 8];
            end
            S_DONE: begin
                if_done_out = ~owner_d;
                d_done_out  = owner_d;
            end
            default: begin
            end
        endcase
    end

    assign if_data_out = if_data;
    assign d_rdata_out = d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_mem_ctrl                                          |
// | Description : Self-checking bench for mem_ctrl with a byte RAM     |
// |               model and a transaction-level reference memory.      |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
module tb_mem_ctrl;

    localparam int AW        = 17;
    localparam int RAM_BYTES = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          if_req;
    logic [31:0]   if_addr;
    logic          if_done;
    logic [31:0]   if_data;
    logic          d_req;
    logic          d_we;
    logic [1:0]    d_size;
    logic [31:0]   d_addr;
    logic [31:0]   d_wdata;
    logic          d_done;
    logic [31:0]   d_rdata;
    logic          ram_en;
    logic          ram_r_nw;
    logic [AW-1:0] ram_a;
    logic [7:0]    ram_dout;
    logic [7:0]    ram_q;

    logic [7:0]    ram     [0:RAM_BYTES-1];
    logic [7:0]    ref_mem [0:RAM_BYTES-1];

    int            n_cmp;
    int            n_bad;
    int            en_cnt;
    int            pin_viol;
    bit            model_last_d;
    logic [31:0]   exp_if;
    logic [31:0]   exp_dr;
    bit            d_hold_ok;

    mem_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk_in       (clk),
        .rst_n_in     (rst_n),
        .if_req_in    (if_req),
        .if_addr_in   (if_addr),
        .if_done_out  (if_done),
        .if_data_out  (if_data),
        .d_req_in     (d_req),
        .d_we_in      (d_we),
        .d_size_in    (d_size),
        .d_addr_in    (d_addr),
        .d_wdata_in   (d_wdata),
        .d_done_out   (d_done),
        .d_rdata_out  (d_rdata),
        .ram_en_out   (ram_en),
        .ram_r_nw_out (ram_r_nw),
        .ram_a_out    (ram_a),
        .ram_d_out    (ram_dout),
        .ram_d_in     (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37) ^ (i >>> 7));
    endfunction

    // Synchronous 8-bit RAM with one-cycle read latency.
    initial begin
        ram_q = 8'd0;
        for (int i = 0; i < RAM_BYTES; i++) ram[i] = init_byte(i);
        forever begin
            @(posedge clk);
            if (ram_en) begin
                if (ram_r_nw) ram[ram_a] <= ram_dout;
                else          ram_q      <= ram[ram_a];
            end
        end
    end

    // Pin hygiene outside beats, and a running count of beat cycles.
    always @(negedge clk) begin
        if (ram_en) en_cnt++;
        else if (rst_n && (ram_a != '0 || ram_dout != 8'd0 || ram_r_nw)) pin_viol++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic int nb(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
        logic [31:0] r;
        r = 32'd0;
        for (int k = 0; k < n; k++) r[8*k +: 8] = ref_mem[AW'(a + 32'(k))];
        return r;
    endfunction

    task automatic model_write(input logic [31:0] a, input int n, input logic [31:0] w);
        for (int k = 0; k < n; k++) ref_mem[AW'(a + 32'(k))] = w[8*k +: 8];
    endtask

    // Issue fetch and/or load-store from the current pin values, follow to completion.
    task automatic go(input bit f, input bit d, input bit perturb);
        int          exp_f, exp_d, cyc, ld, en0, tot, extra;
        bit          pf, pd, win_d, dw;
        logic [31:0] fa, da, dwd;
        logic [1:0]  ds;
        fa = if_addr; da = d_addr; ds = d_size; dw = d_we; dwd = d_wdata;
        if_req = f;
        d_req  = d;
        ld     = dw ? nb(ds) + 1 : nb(ds) + 2;
        tot    = (f ? 4 : 0) + (d ? nb(ds) : 0);
        win_d  = d && (!f || !model_last_d);
        if (f && d) begin
            if (win_d) begin exp_d = ld; exp_f = ld + 1 + 6; end
            else       begin exp_f = 6;  exp_d = 6 + 1 + ld; end
        end else begin
            exp_f = 6;
            exp_d = ld;
        end
        en0 = en_cnt; pf = f; pd = d; cyc = 0;
        while ((pf || pd) && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (perturb && cyc == 2) begin
                d_req  = 1'b0;
                d_addr = $urandom;
            end
            if (if_done) begin
                if (!pf) chk("f_spurious", 1, 0);
                else begin
                    chk("f_lat", cyc, exp_f);
                    exp_if = model_read(fa, 4);
                    chk("f_data", if_data, exp_if);
                    if_req = 1'b0; pf = 0; model_last_d = 0;
                end
            end
            if (d_done) begin
                if (!pd) chk("d_spurious", 1, 0);
                else begin
                    chk("d_lat", cyc, exp_d);
                    if (!dw) begin
                        exp_dr = model_read(da, nb(ds));
                        d_hold_ok = 1;
                        chk("d_data", d_rdata, exp_dr);
                    end else begin
                        model_write(da, nb(ds), dwd);
                        d_hold_ok = 0;
                    end
                    d_req = 1'b0; pd = 0; model_last_d = 1;
                end
            end
        end
        if (pf || pd) chk("timeout", {30'd0, pf, pd}, 0);
        extra = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (if_done || d_done) extra++;
        end
        chk("extra_done", extra, 0);
        chk("beats", en_cnt - en0, tot);
        chk("f_hold", if_data, exp_if);
        if (d_hold_ok) chk("d_hold", d_rdata, exp_dr);
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] hi, lo;
        hi = $urandom & 32'hFFFE_0000;
        case ($urandom_range(0, 2))
            0:       lo = 32'h100 + $urandom_range(0, 15);
            1:       lo = 32'h1FFFC + $urandom_range(0, 5);
            default: lo = $urandom & 32'h1FFFF;
        endcase
        return hi | (lo & 32'h1FFFF);
    endfunction

    initial begin
        logic [31:0] w;
        int          extra;
        n_cmp = 0; n_bad = 0; en_cnt = 0; pin_viol = 0;
        model_last_d = 0; exp_if = 0; exp_dr = 0; d_hold_ok = 1;
        for (int i = 0; i < RAM_BYTES; i++) ref_mem[i] = init_byte(i);
        rst_n = 1'b0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0;
        d_size = 0; d_addr = 0; d_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_if_done", if_done, 0);
        chk("rst_d_done", d_done, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_a", 32'(ram_a), 0);
        chk("rst_if_data", if_data, 0);
        chk("rst_d_rdata", d_rdata, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Word store then fetch of the same word.
        d_we = 1; d_size = 2'b10; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
        go(0, 1, 0);
        w = 32'hDEADBEEF;
        for (int k = 0; k < 4; k++) chk("ram_store", 32'(ram[AW'(32'h100 + 32'(k))]), 32'(w[8*k +: 8]));
        if_addr = 32'h100;
        go(1, 0, 0);
        chk("fetch_word", if_data, 32'hDEADBEEF);

        // Byte and half loads.
        d_we = 0; d_size = 2'b00; d_addr = 32'h102;
        go(0, 1, 0);
        chk("load_byte", d_rdata, 32'h000000AD);
        d_size = 2'b01; d_addr = 32'h101;
        go(0, 1, 0);
        chk("load_half", d_rdata, 32'h0000ADBE);

        // Simultaneous requests, alternating winners.
        for (int r = 0; r < 4; r++) begin
            if_addr = pick_addr(); d_addr = pick_addr();
            d_we = 0; d_size = 2'($urandom_range(0, 3));
            go(1, 1, 0);
        end

        // Store wrapping the top of the RAM, then read it back.
        d_we = 1; d_size = 2'b10; d_addr = 32'h1FFFE; d_wdata = 32'h11223344;
        go(0, 1, 0);
        chk("wrap_1fffe", 32'(ram[17'h1FFFE]), 32'h44);
        chk("wrap_1ffff", 32'(ram[17'h1FFFF]), 32'h33);
        chk("wrap_00000", 32'(ram[17'h00000]), 32'h22);
        chk("wrap_00001", 32'(ram[17'h00001]), 32'h11);
        d_we = 0;
        go(0, 1, 0);
        chk("wrap_load", d_rdata, 32'h11223344);

        // Requester withdraws and changes address mid-load.
        d_we = 0; d_size = 2'b10; d_addr = 32'h104;
        go(0, 1, 1);

        // Reset during beat 2 of a word store.
        d_we = 1; d_size = 2'b10; d_addr = 32'h200; d_wdata = 32'hCAFEF00D;
        d_req = 1; if_req = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_ram_en", ram_en, 0);
        chk("arst_ram_a", 32'(ram_a), 0);
        chk("arst_ram_d", 32'(ram_dout), 0);
        chk("arst_d_done", d_done, 0);
        chk("arst_d_rdata", d_rdata, 0);
        chk("arst_if_data", if_data, 0);
        model_write(32'h200, 2, 32'h0000F00D);
        model_last_d = 0; exp_if = 0; exp_dr = 0; d_hold_ok = 1;
        d_req = 0;
        extra = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (if_done || d_done) extra++;
        end
        chk("arst_no_done", extra, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        if_addr = 32'h0;
        go(1, 0, 0);
        d_we = 0; d_size = 2'b10; d_addr = 32'h200;
        go(0, 1, 0);

        // Randomised mix of fetches, loads and stores.
        for (int t = 0; t < 40; t++) begin
            int sel;
            sel     = $urandom_range(0, 2);
            if_addr = pick_addr();
            d_addr  = pick_addr();
            d_we    = 1'($urandom_range(0, 1));
            d_size  = 2'($urandom_range(0, 3));
            d_wdata = $urandom;
            go(sel != 1, sel != 0, 0);
        end

        chk("idle_pins", pin_viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
